// File: rtl/backbone_seq_ctrl.sv
// Frame sequencer in front of the backbone-to-vinput datapath.
// Per frame: one-cycle config load strobes, then J backbone words forwarded
// from an upstream stream (first one tagged), credit-limited so that at most
// MAX_OUTSTANDING backbones are awaiting their OUT_PER_BB results. Completion
// is reported with frame_done; a stalled result stream raises err_timeout.
module backbone_seq_ctrl #(
    parameter int unsigned J               = 14,
    parameter int unsigned OUT_PER_BB      = 7,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT         = 1024,
    localparam int unsigned CNT_W          = $clog2(J * OUT_PER_BB + 1),
    localparam int unsigned BB_W           = $clog2(J + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      bb_in,
    input  logic             bb_in_tvalid,
    output logic             bb_in_tready,
    output logic [63:0]      backbone,
    output logic             backbone_tvalid,
    output logic             first_backbone,
    output logic             x_initial_tvalid,
    output logic             alpha_u_tvalid,
    input  logic             vinput_tvalid,
    output logic             busy,
    output logic             frame_done,
    output logic             err_timeout,
    output logic [BB_W-1:0]  bb_sent,
    output logic [CNT_W-1:0] vin_count
);

    localparam int unsigned RC_W = (OUT_PER_BB > 1) ? $clog2(OUT_PER_BB) : 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    localparam logic [BB_W-1:0]  J_V     = BB_W'(J);
    localparam logic [BB_W-1:0]  J_LAST  = BB_W'(J - 1);
    localparam logic [BB_W-1:0]  MAX_V   = BB_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] TOTAL_V = CNT_W'(J * OUT_PER_BB);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(OUT_PER_BB - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StCfg, StFirst, StStream, StDrain, StDone, StErr
    } state_t;

    state_t           state;
    logic [BB_W-1:0]  bb_completed;
    logic [RC_W-1:0]  res_cnt;      // results seen for the oldest open backbone
    logic [TO_W-1:0]  to_cnt;
    logic [BB_W-1:0]  outstanding;
    logic             active;
    logic             accept;
    logic [CNT_W-1:0] vin_next;

    // Credit, handshake and saturating result count, all from pre-update values
    assign outstanding  = bb_sent - bb_completed;
    assign active       = (state == StFirst) || (state == StStream) || (state == StDrain);
    assign bb_in_tready = ((state == StFirst) || (state == StStream)) &&
                          (bb_sent < J_V) && (outstanding < MAX_V);
    assign accept       = bb_in_tvalid && bb_in_tready;
    assign vin_next     = (active && vinput_tvalid && (vin_count != TOTAL_V)) ?
                          vin_count + 1'b1 : vin_count;
    assign busy         = (state != StIdle) && (state != StErr);

    // Frame FSM with registered strobes, counters and forwarded word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= StIdle;
            backbone         <= 64'h0;
            backbone_tvalid  <= 1'b0;
            first_backbone   <= 1'b0;
            x_initial_tvalid <= 1'b0;
            alpha_u_tvalid   <= 1'b0;
            frame_done       <= 1'b0;
            err_timeout      <= 1'b0;
            bb_sent          <= '0;
            vin_count        <= '0;
            bb_completed     <= '0;
            res_cnt          <= '0;
            to_cnt           <= '0;
        end else begin
            backbone_tvalid  <= 1'b0;
            first_backbone   <= 1'b0;
            x_initial_tvalid <= 1'b0;
            alpha_u_tvalid   <= 1'b0;
            frame_done       <= 1'b0;
            case (state)
                StIdle, StErr: begin
                    if (start) begin
                        bb_sent          <= '0;
                        vin_count        <= '0;
                        bb_completed     <= '0;
                        res_cnt          <= '0;
                        to_cnt           <= '0;
                        err_timeout      <= 1'b0;
                        x_initial_tvalid <= 1'b1;
                        alpha_u_tvalid   <= 1'b1;
                        state            <= StCfg;
                    end
                end
                StCfg: state <= StFirst;
                StFirst, StStream, StDrain: begin
                    if (accept) begin
                        backbone        <= bb_in;
                        backbone_tvalid <= 1'b1;
                        first_backbone  <= (state == StFirst);
                        bb_sent         <= bb_sent + 1'b1;
                    end
                    if (vinput_tvalid) begin
                        if (res_cnt == RC_LAST) begin
                            res_cnt      <= '0;
                            bb_completed <= bb_completed + 1'b1;
                        end else begin
                            res_cnt <= res_cnt + 1'b1;
                        end
                    end
                    vin_count <= vin_next;
                    if (state == StFirst && accept) begin
                        state <= (J == 1) ? StDrain : StStream;
                    end else if (state == StStream && accept && bb_sent == J_LAST) begin
                        state <= StDrain;
                    end else if (state == StDrain && vin_next == TOTAL_V) begin
                        state      <= StDone;
                        frame_done <= 1'b1;
                    end
                    // Stall watchdog only runs while results are actually owed
                    if (vinput_tvalid || outstanding == '0) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt      <= '0;
                        err_timeout <= 1'b1;
                        frame_done  <= 1'b0;
                        state       <= StErr;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_backbone_seq_ctrl.sv
// Bench for backbone_seq_ctrl: two instances (credit limit 4 and 2) driven
// by directed scenarios and random frames, checked against a count-level model.
module tb_backbone_seq_ctrl;

    localparam int J     = 4;
    localparam int OPB   = 2;
    localparam int TOTAL = J * OPB;
    localparam int TOUT  = 16;

    localparam int PH_IDLE = 0, PH_CFG = 1, PH_FIRST = 2, PH_STREAM = 3;
    localparam int PH_DRAIN = 4, PH_DONE = 5, PH_ERR = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start_s[2], tv_s[2], vin_s[2];
    logic [63:0] bbin_s[2];
    logic        rdy_s[2], bbv_s[2], first_s[2], xi_s[2], au_s[2];
    logic        busy_s[2], done_s[2], err_s[2];
    logic [63:0] bb_s[2];
    logic [2:0]  sent_s[2];
    logic [3:0]  vcnt_s[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        backbone_seq_ctrl #(
            .J(J), .OUT_PER_BB(OPB), .MAX_OUTSTANDING(g == 0 ? 4 : 2), .TIMEOUT(TOUT)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start_s[g]),
            .bb_in(bbin_s[g]), .bb_in_tvalid(tv_s[g]), .bb_in_tready(rdy_s[g]),
            .backbone(bb_s[g]), .backbone_tvalid(bbv_s[g]), .first_backbone(first_s[g]),
            .x_initial_tvalid(xi_s[g]), .alpha_u_tvalid(au_s[g]),
            .vinput_tvalid(vin_s[g]), .busy(busy_s[g]), .frame_done(done_s[g]),
            .err_timeout(err_s[g]), .bb_sent(sent_s[g]), .vin_count(vcnt_s[g])
        );
    end

    always #5 clk = ~clk;

    int total, bad;

    // Reference model: frame phase plus plain counts
    int          m_ph[2], m_sent[2], m_vin[2], m_idle[2];
    bit          m_err[2], e_bbv[2], e_first[2], e_cfg[2], e_done[2], e_rdy[2];
    logic [63:0] e_bb[2];
    logic        o_rdy[2];

    function automatic int max_out(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic bit model_ready(input int d);
        return (m_ph[d] == PH_FIRST || m_ph[d] == PH_STREAM) && m_sent[d] < J &&
               (m_sent[d] - m_vin[d] / OPB) < max_out(d);
    endfunction

    function automatic bit pending(input int d);
        return m_vin[d] < m_sent[d] * OPB;
    endfunction

    function automatic bit is_active(input int d);
        return m_ph[d] == PH_FIRST || m_ph[d] == PH_STREAM || m_ph[d] == PH_DRAIN;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = PH_IDLE; m_sent[d] = 0; m_vin[d] = 0; m_idle[d] = 0; m_err[d] = 0;
            e_bbv[d] = 0; e_first[d] = 0; e_cfg[d] = 0; e_done[d] = 0; e_bb[d] = 64'h0;
        end
    endtask

    task automatic model_step(input int d, input bit st, input bit h, input logic [63:0] w,
                              input bit v);
        int outst;
        int nph;
        outst = m_sent[d] - m_vin[d] / OPB;
        e_bbv[d] = 0; e_first[d] = 0; e_cfg[d] = 0; e_done[d] = 0;
        case (m_ph[d])
            PH_IDLE, PH_ERR: begin
                if (st) begin
                    m_sent[d] = 0; m_vin[d] = 0; m_idle[d] = 0; m_err[d] = 0;
                    e_cfg[d] = 1; m_ph[d] = PH_CFG;
                end
            end
            PH_CFG:  m_ph[d] = PH_FIRST;
            PH_DONE: m_ph[d] = PH_IDLE;
            default: begin
                nph = m_ph[d];
                if (h) begin
                    if (m_ph[d] == PH_FIRST) nph = PH_STREAM;
                    m_sent[d]++;
                    e_bb[d] = w; e_bbv[d] = 1; e_first[d] = (m_ph[d] == PH_FIRST);
                    if (m_ph[d] == PH_STREAM && m_sent[d] == J) nph = PH_DRAIN;
                end
                if (v && m_vin[d] < TOTAL) m_vin[d]++;
                if (m_ph[d] == PH_DRAIN && m_vin[d] == TOTAL) begin
                    nph = PH_DONE; e_done[d] = 1;
                end
                if (v || outst == 0) m_idle[d] = 0;
                else if (m_idle[d] == TOUT - 1) begin
                    m_idle[d] = 0; m_err[d] = 1; e_done[d] = 0; nph = PH_ERR;
                end else m_idle[d]++;
                m_ph[d] = nph;
            end
        endcase
    endtask

    // One clock: called and returning at a falling edge, inputs held across the rise
    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            e_rdy[d] = model_ready(d);
            o_rdy[d] = rdy_s[d];
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            model_step(d, start_s[d], tv_s[d] && e_rdy[d], bbin_s[d], vin_s[d]);
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 0; tv_s[d] = 0; vin_s[d] = 0; bbin_s[d] = 64'h0;
        end
    endtask

    task automatic start_frame(input int d);
        start_s[d] = 1; tick(); start_s[d] = 0; tick();
    endtask

    // Feeds words and answers all owed results until frame_done or budget expiry
    task automatic finish_frame(input int d, output bit saw_done);
        saw_done = 0;
        for (int i = 0; i < 120 && !saw_done; i++) begin
            tv_s[d] = 1; bbin_s[d] = {$urandom, $urandom};
            vin_s[d] = is_active(d) && pending(d);
            tick();
            if (done_s[d] === 1'b1) saw_done = 1;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++; if (rdy_s[d] !== 1'b0) begin bad++; $display("FAIL reset_tready d=%0d got=%b want=0", d, rdy_s[d]); end
            total++; if (bb_s[d] !== 64'h0) begin bad++; $display("FAIL reset_backbone d=%0d got=%h want=0", d, bb_s[d]); end
            total++; if (bbv_s[d] !== 1'b0) begin bad++; $display("FAIL reset_bbv d=%0d got=%b want=0", d, bbv_s[d]); end
            total++; if (first_s[d] !== 1'b0) begin bad++; $display("FAIL reset_first d=%0d got=%b want=0", d, first_s[d]); end
            total++; if ({xi_s[d], au_s[d]} !== 2'b00) begin bad++; $display("FAIL reset_cfg d=%0d got=%b%b want=00", d, xi_s[d], au_s[d]); end
            total++; if ({busy_s[d], done_s[d], err_s[d]} !== 3'b000) begin bad++; $display("FAIL reset_status d=%0d got=%b%b%b want=000", d, busy_s[d], done_s[d], err_s[d]); end
            total++; if (sent_s[d] !== 3'd0 || vcnt_s[d] !== 4'd0) begin bad++; $display("FAIL reset_counts d=%0d got=%0d/%0d want=0/0", d, sent_s[d], vcnt_s[d]); end
        end
        rst = 0;
        model_reset();
    endtask

    task automatic test_idle_vin();
        for (int d = 0; d < 2; d++) vin_s[d] = 1;
        repeat (5) tick();
        idle_inputs();
        for (int d = 0; d < 2; d++) begin
            total++; if (vcnt_s[d] !== 4'd0) begin bad++; $display("FAIL idle_vin_count d=%0d got=%0d want=0", d, vcnt_s[d]); end
            total++; if (busy_s[d] !== 1'b0) begin bad++; $display("FAIL idle_busy d=%0d got=%b want=0", d, busy_s[d]); end
        end
    endtask

    task automatic test_basic();
        logic [63:0] words[4];
        words[0] = 64'h3FF0_0000_0000_0000;  // 1.0
        words[1] = 64'h4000_0000_0000_0000;  // 2.0
        words[2] = 64'h4008_0000_0000_0000;  // 3.0
        words[3] = 64'h4010_0000_0000_0000;  // 4.0
        start_s[0] = 1; tick(); start_s[0] = 0;
        total++; if ({xi_s[0], au_s[0], busy_s[0]} !== 3'b111) begin bad++; $display("FAIL basic_cfg_strobe got=%b%b%b want=111", xi_s[0], au_s[0], busy_s[0]); end
        tick();
        total++; if ({xi_s[0], au_s[0]} !== 2'b00) begin bad++; $display("FAIL basic_cfg_one_cycle got=%b%b want=00", xi_s[0], au_s[0]); end
        for (int i = 0; i < 4; i++) begin
            tv_s[0] = 1; bbin_s[0] = words[i];
            start_s[0] = (i == 2);  // must be ignored mid-stream
            tick();
            start_s[0] = 0;
            total++; if (o_rdy[0] !== 1'b1) begin bad++; $display("FAIL basic_tready w%0d got=%b want=1", i, o_rdy[0]); end
            total++; if (bbv_s[0] !== 1'b1 || bb_s[0] !== words[i]) begin bad++; $display("FAIL basic_word w%0d got=%b/%h want=1/%h", i, bbv_s[0], bb_s[0], words[i]); end
            total++; if (first_s[0] !== (i == 0)) begin bad++; $display("FAIL basic_first w%0d got=%b want=%b", i, first_s[0], i == 0); end
            total++; if (xi_s[0] !== 1'b0 || sent_s[0] !== 3'(i + 1)) begin bad++; $display("FAIL basic_start_ignored w%0d got=%b/%0d want=0/%0d", i, xi_s[0], sent_s[0], i + 1); end
        end
        tv_s[0] = 0; tick();
        total++; if (bbv_s[0] !== 1'b0 || rdy_s[0] !== 1'b0) begin bad++; $display("FAIL basic_after_last got=%b/%b want=0/0", bbv_s[0], rdy_s[0]); end
        for (int k = 0; k < 8; k++) begin
            vin_s[0] = 1; tick();
            total++; if (done_s[0] !== (k == 7)) begin bad++; $display("FAIL basic_done p%0d got=%b want=%b", k, done_s[0], k == 7); end
        end
        vin_s[0] = 0;
        total++; if (sent_s[0] !== 3'd4 || vcnt_s[0] !== 4'd8) begin bad++; $display("FAIL basic_counts got=%0d/%0d want=4/8", sent_s[0], vcnt_s[0]); end
        tick();
        total++; if ({done_s[0], busy_s[0]} !== 2'b00 || vcnt_s[0] !== 4'd8) begin bad++; $display("FAIL basic_hold got=%b%b/%0d want=00/8", done_s[0], busy_s[0], vcnt_s[0]); end
    endtask

    task automatic test_credit();
        bit ok;
        start_frame(1);
        tv_s[1] = 1; bbin_s[1] = {$urandom, $urandom};
        repeat (6) tick();
        total++; if (sent_s[1] !== 3'd2 || rdy_s[1] !== 1'b0) begin bad++; $display("FAIL credit_stall got=%0d/%b want=2/0", sent_s[1], rdy_s[1]); end
        vin_s[1] = 1; tick(); tick(); vin_s[1] = 0;
        total++; if (sent_s[1] !== 3'd2 || rdy_s[1] !== 1'b1) begin bad++; $display("FAIL credit_release got=%0d/%b want=2/1", sent_s[1], rdy_s[1]); end
        tick();
        total++; if (sent_s[1] !== 3'd3 || rdy_s[1] !== 1'b0) begin bad++; $display("FAIL credit_one_more got=%0d/%b want=3/0", sent_s[1], rdy_s[1]); end
        repeat (2) tick();
        total++; if (sent_s[1] !== 3'd3) begin bad++; $display("FAIL credit_no_extra got=%0d want=3", sent_s[1]); end
        tv_s[1] = 0;
        finish_frame(1, ok);
        total++; if (!ok || sent_s[1] !== 3'd4 || vcnt_s[1] !== 4'd8) begin bad++; $display("FAIL credit_finish got=%b/%0d/%0d want=1/4/8", ok, sent_s[1], vcnt_s[1]); end
    endtask

    task automatic test_same_cycle();
        bit ok;
        start_frame(1);
        tv_s[1] = 1; bbin_s[1] = {$urandom, $urandom}; tick(); tv_s[1] = 0;
        vin_s[1] = 1; tick();
        tv_s[1] = 1; vin_s[1] = 1; tick();
        total++; if (o_rdy[1] !== 1'b1 || bbv_s[1] !== 1'b1) begin bad++; $display("FAIL same_handshake got=%b/%b want=1/1", o_rdy[1], bbv_s[1]); end
        total++; if (sent_s[1] !== 3'd2 || vcnt_s[1] !== 4'd2 || rdy_s[1] !== 1'b1) begin bad++; $display("FAIL same_counts got=%0d/%0d/%b want=2/2/1", sent_s[1], vcnt_s[1], rdy_s[1]); end
        vin_s[1] = 0; tick();
        vin_s[1] = 1; tick(); tick();
        // Completion with credit exhausted: no word accepted on that same edge
        total++; if (sent_s[1] !== 3'd3 || vcnt_s[1] !== 4'd4 || bbv_s[1] !== 1'b0) begin bad++; $display("FAIL same_old_credit got=%0d/%0d/%b want=3/4/0", sent_s[1], vcnt_s[1], bbv_s[1]); end
        total++; if (rdy_s[1] !== 1'b1) begin bad++; $display("FAIL same_ready_after got=%b want=1", rdy_s[1]); end
        tv_s[1] = 0; vin_s[1] = 0;
        finish_frame(1, ok);
        total++; if (!ok) begin bad++; $display("FAIL same_finish got=0 want=1"); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        start_frame(0);
        tv_s[0] = 1;
        repeat (4) begin bbin_s[0] = {$urandom, $urandom}; tick(); end
        tv_s[0] = 0;
        vin_s[0] = 1; repeat (3) tick(); vin_s[0] = 0;
        n = 0;
        for (int i = 0; i < 40 && err_s[0] !== 1'b1; i++) begin tick(); n++; end
        total++; if (n != 16) begin bad++; $display("FAIL timeout_cycles got=%0d want=16", n); end
        total++; if ({err_s[0], busy_s[0], rdy_s[0]} !== 3'b100) begin bad++; $display("FAIL timeout_state got=%b%b%b want=100", err_s[0], busy_s[0], rdy_s[0]); end
        repeat (3) tick();
        total++; if (err_s[0] !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b want=1", err_s[0]); end
        start_s[0] = 1; tick(); start_s[0] = 0;
        total++; if (err_s[0] !== 1'b0 || xi_s[0] !== 1'b1 || sent_s[0] !== 3'd0 || vcnt_s[0] !== 4'd0) begin bad++; $display("FAIL timeout_restart got=%b/%b/%0d/%0d want=0/1/0/0", err_s[0], xi_s[0], sent_s[0], vcnt_s[0]); end
        finish_frame(0, ok);
        total++; if (!ok || vcnt_s[0] !== 4'd8) begin bad++; $display("FAIL timeout_recover got=%b/%0d want=1/8", ok, vcnt_s[0]); end
    endtask

    task automatic test_async_reset();
        bit ok;
        start_frame(0);
        tv_s[0] = 1; bbin_s[0] = 64'hDEAD_BEEF_0123_4567; tick(); tick();
        total++; if (sent_s[0] !== 3'd2 || bbv_s[0] !== 1'b1) begin bad++; $display("FAIL areset_pre got=%0d/%b want=2/1", sent_s[0], bbv_s[0]); end
        #2 rst = 1;
        #1;
        total++; if (bb_s[0] !== 64'h0 || bbv_s[0] !== 1'b0 || rdy_s[0] !== 1'b0) begin bad++; $display("FAIL areset_outputs got=%h/%b/%b want=0/0/0", bb_s[0], bbv_s[0], rdy_s[0]); end
        total++; if (busy_s[0] !== 1'b0 || sent_s[0] !== 3'd0 || vcnt_s[0] !== 4'd0) begin bad++; $display("FAIL areset_state got=%b/%0d/%0d want=0/0/0", busy_s[0], sent_s[0], vcnt_s[0]); end
        idle_inputs();
        @(negedge clk);
        rst = 0;
        model_reset();
        start_frame(0);
        finish_frame(0, ok);
        total++; if (!ok || sent_s[0] !== 3'd4 || vcnt_s[0] !== 4'd8) begin bad++; $display("FAIL areset_frame got=%b/%0d/%0d want=1/4/8", ok, sent_s[0], vcnt_s[0]); end
    endtask

    task automatic test_random();
        for (int d = 0; d < 2; d++) begin
            for (int f = 0; f < 5; f++) begin
                int pre;
                bit fin;
                pre = $urandom_range(4, 1);
                fin = 0;
                for (int c = 0; c < 220 && !fin; c++) begin
                    start_s[d] = (c == pre) || (c > pre && $urandom_range(15) == 0);
                    tv_s[d] = 1'($urandom_range(1));
                    bbin_s[d] = {$urandom, $urandom};
                    vin_s[d] = is_active(d) ? (pending(d) && $urandom_range(2) != 0)
                                            : 1'($urandom_range(1));
                    tick();
                    total++; if (o_rdy[d] !== e_rdy[d]) begin bad++; $display("FAIL rnd_tready d=%0d c=%0d got=%b want=%b", d, c, o_rdy[d], e_rdy[d]); end
                    total++; if (bbv_s[d] !== e_bbv[d] || first_s[d] !== e_first[d]) begin bad++; $display("FAIL rnd_strobe d=%0d c=%0d got=%b%b want=%b%b", d, c, bbv_s[d], first_s[d], e_bbv[d], e_first[d]); end
                    total++; if (e_bbv[d] && bb_s[d] !== e_bb[d]) begin bad++; $display("FAIL rnd_word d=%0d c=%0d got=%h want=%h", d, c, bb_s[d], e_bb[d]); end
                    total++; if (xi_s[d] !== e_cfg[d] || au_s[d] !== e_cfg[d]) begin bad++; $display("FAIL rnd_cfg d=%0d c=%0d got=%b%b want=%b", d, c, xi_s[d], au_s[d], e_cfg[d]); end
                    total++; if (done_s[d] !== e_done[d] || err_s[d] !== m_err[d]) begin bad++; $display("FAIL rnd_done_err d=%0d c=%0d got=%b%b want=%b%b", d, c, done_s[d], err_s[d], e_done[d], m_err[d]); end
                    total++; if (busy_s[d] !== (m_ph[d] != PH_IDLE && m_ph[d] != PH_ERR)) begin bad++; $display("FAIL rnd_busy d=%0d c=%0d got=%b", d, c, busy_s[d]); end
                    total++; if (sent_s[d] !== 3'(m_sent[d]) || vcnt_s[d] !== 4'(m_vin[d])) begin bad++; $display("FAIL rnd_counts d=%0d c=%0d got=%0d/%0d want=%0d/%0d", d, c, sent_s[d], vcnt_s[d], m_sent[d], m_vin[d]); end
                    if (c > pre && (m_ph[d] == PH_IDLE || m_ph[d] == PH_ERR)) fin = 1;
                end
                idle_inputs();
                total++; if (!fin) begin bad++; $display("FAIL rnd_frame_bound d=%0d f=%0d got=unfinished want=finished", d, f); end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_idle_vin();
        test_basic();
        test_credit();
        test_same_cycle();
        test_timeout();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/backbone_seq_ctrl.md
Name: backbone_seq_ctrl

Overview:
- Frame-level sequencer in front of the backbone-to-vinput datapath.
- Per frame it pulses the x_initial/alpha_u load strobes, then forwards J backbone words from an upstream AXI-stream, tagging the first one with first_backbone.
- It credit-limits the words in flight so the datapath's internal backbone FIFO never overflows, counts returned vinput results, and reports frame completion or a stall timeout.

Parameters:
- J, 14: backbones per frame.
- OUT_PER_BB, 7: vinput results the datapath produces per backbone.
- MAX_OUTSTANDING, 4: maximum backbones forwarded but not yet fully answered (1..J).
- TIMEOUT, 1024: idle cycles without vinput_tvalid, while results are pending, before the error is raised.
- Local CNT_W = $clog2(J*OUT_PER_BB+1); BB_W = $clog2(J+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame start request (ignored unless IDLE or ERR).
- bb_in  in  64  upstream backbone word (IEEE double).
- bb_in_tvalid  in  1  upstream valid.
- bb_in_tready  out  1  upstream ready.
- backbone  out  64  word to datapath.
- backbone_tvalid  out  1  datapath word strobe.
- first_backbone  out  1  marks first word of frame (coincident with backbone_tvalid).
- x_initial_tvalid  out  1  config load strobe.
- alpha_u_tvalid  out  1  config load strobe.
- vinput_tvalid  in  1  datapath result strobe.
- busy  out  1  high in every state except IDLE and ERR.
- frame_done  out  1  one-cycle completion pulse.
- err_timeout  out  1  sticky stall error.
- bb_sent  out  BB_W  backbones forwarded this frame.
- vin_count  out  CNT_W  results received this frame.

Behaviour:
- Asynchronous reset. All outputs and counters go to 0, the FSM goes to IDLE, and backbone is cleared to 64'h0.
- States: IDLE, CFG, FIRST, STREAM, DRAIN, DONE, ERR.
- IDLE:
  - start=1 clears bb_sent, vin_count, per-backbone result counter and timeout counter, then goes to CFG.
- CFG:
  - x_initial_tvalid=alpha_u_tvalid=1 for exactly one cycle, then goes to FIRST.
- Credit:
  - outstanding = bb_sent - bb_completed.
  - bb_completed increments when the per-backbone result counter reaches OUT_PER_BB-1 and vinput_tvalid=1; that counter then wraps to 0.
- bb_in_tready:
  - Combinational.
  - Equals (state==FIRST or STREAM) && bb_sent<J && outstanding<MAX_OUTSTANDING.
- Accept and forward:
  - A handshake (tvalid && tready) at edge k causes a registered backbone=bb_in and backbone_tvalid=1 in cycle k+1 (latency 1), and bb_sent++.
  - In FIRST, the forwarded word also drives first_backbone=1; the FSM then goes to STREAM, or to DRAIN when J=1.
  - In STREAM, the handshake that makes bb_sent==J moves the FSM to DRAIN.
- vinput_tvalid:
  - Counted in any of FIRST/STREAM/DRAIN.
  - Pulses arriving in IDLE, CFG, DONE or ERR are ignored and do not change vin_count.
  - A pulse in the same cycle as an accepted word updates both counters, and the credit check uses pre-update values.
- DRAIN:
  - When vin_count reaches J*OUT_PER_BB, the FSM goes to DONE.
- DONE:
  - frame_done=1 for one cycle, then back to IDLE.
  - bb_sent and vin_count hold their final values until the next start.
- Timeout:
  - The counter runs in FIRST/STREAM/DRAIN while outstanding>0.
  - It is cleared on every vinput_tvalid or when outstanding==0.
  - Reaching TIMEOUT-1 moves the FSM to ERR with err_timeout=1 and tready=0.
  - ERR is left only by start, which clears err_timeout and proceeds as in IDLE.
- Saturation and overruns:
  - vin_count saturates at J*OUT_PER_BB.
  - An extra vinput_tvalid in DRAIN after completion is impossible because the FSM leaves in the same cycle.
- Reset mid-frame aborts immediately. Any upstream word not handshaken is not consumed.

Test Plan:
- J=4, OUT_PER_BB=2, MAX_OUTSTANDING=4: start, then 4 words 1.0..4.0 with tvalid held, then 8 vinput pulses.
  - x/alpha strobes one cycle after start.
  - first_backbone only with 1.0.
  - backbone_tvalid one cycle after each handshake.
  - frame_done 1 cycle after the 8th pulse.
  - bb_sent=4, vin_count=8.
- MAX_OUTSTANDING=2, no vinput: only 2 words accepted and tready stays 0; one vinput pair releases exactly one more word.
- Simultaneous handshake and the vinput completing a backbone in the same cycle: the credit check uses old outstanding, and both counters update that cycle.
- TIMEOUT=16, stop vinput after 3 pulses: err_timeout rises after 16 idle cycles, busy=0, tready=0; start clears it and a new frame completes normally.
- vinput pulses while IDLE: vin_count stays 0. start pulsed during STREAM: ignored.
- rst asserted mid-STREAM: all outputs return to 0 asynchronously and the FSM is IDLE; a following full frame completes.
